ex_mem_buffer: RTL and testbench



---
 rtl/ex_mem_buffer_pkg.sv | 38 +++
 rtl/ex_mem_buffer_reg.sv | 35 +++
 rtl/ex_mem_buffer.sv | 162 ++++++++++++++++
 tb/tb_ex_mem_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_buffer_pkg.sv
// Shared LC-3b pipeline types used by the EX/MEM buffer: the word and
// register-index types, the control word that travels with each
// instruction, the buffered payload record and the buffer state encoding.
package ex_mem_buffer_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [3:0]  lc3b_opcode;

    // Control word carried alongside each instruction through the pipe.
    typedef struct packed {
        lc3b_opcode opcode;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
    } lc3b_control_word;

    localparam int LC3B_CTRL_W = $bits(lc3b_control_word);

    // One EX result as held in either buffer slot.
    typedef struct packed {
        lc3b_word         pc;
        lc3b_word         alu;
        lc3b_word         br_addr;
        lc3b_word         store_data;
        lc3b_reg          dest;
        lc3b_control_word ctrl;
    } ex_mem_payload_t;

    // EMPTY: nothing held, HALF: main slot only, FULL: main and skid slots.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } ex_mem_state_t;

endpackage

// File: rtl/ex_mem_buffer_reg.sv
// Generic register with load enable and asynchronous active-low clear.
// Used for the main and skid payload slots of the EX/MEM buffer.
module ex_mem_buffer_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Capture the input when loaded, otherwise keep the stored value.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    // Storage flop; reset clears the slot to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: rtl/ex_mem_buffer.sv
// Two-entry skid buffer between the EX and MEM stages.
// The main slot drives out_*; the skid slot catches the one extra result
// EX may hand over in the cycle MEM stalls, so in_ready never depends
// combinationally on out_ready. flush empties the buffer (payload kept,
// state cleared). Defining EX_MEM_FWD_TAP_EN adds fwd_valid/fwd_dest/
// fwd_data, which expose the youngest buffered entry to forwarding logic.
module ex_mem_buffer
    import ex_mem_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [DATA_W-1:0]   in_alu,
    input  logic [DATA_W-1:0]   in_br_addr,
    input  logic [DATA_W-1:0]   in_store_data,
    input  logic [REG_W-1:0]    in_dest,
    input  lc3b_control_word    in_ctrl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_alu,
    output logic [DATA_W-1:0]   out_br_addr,
    output logic [DATA_W-1:0]   out_store_data,
    output logic [REG_W-1:0]    out_dest,
    output lc3b_control_word    out_ctrl
`ifdef EX_MEM_FWD_TAP_EN
    ,
    output logic                fwd_valid,
    output logic [REG_W-1:0]    fwd_dest,
    output logic [DATA_W-1:0]   fwd_data
`endif
);

    // Flat payload layout, MSB to LSB: pc, alu, br_addr, store_data, dest, ctrl.
    localparam int CTRL_W    = $bits(lc3b_control_word);
    localparam int PAYLOAD_W = 4 * DATA_W + REG_W + CTRL_W;

    ex_mem_state_t          state_q;
    ex_mem_state_t          state_d;
    logic                   out_valid_q;
    logic                   out_valid_d;
    logic                   in_ready_q;
    logic                   in_ready_d;

    logic                   acc;
    logic                   dq;
    logic                   main_load;
    logic                   skid_load;
    logic                   main_from_skid;

    logic [PAYLOAD_W-1:0]   in_payload;
    logic [PAYLOAD_W-1:0]   main_in;
    logic [PAYLOAD_W-1:0]   main_q;
    logic [PAYLOAD_W-1:0]   skid_q;

    assign acc = in_valid & in_ready_q;
    assign dq  = out_valid_q & out_ready;

    assign in_payload = {in_pc, in_alu, in_br_addr, in_store_data, in_dest, in_ctrl};
    assign main_in    = main_from_skid ? skid_q : in_payload;

    // Next-state and slot-load decode; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d   = HALF;
                        main_load = 1'b1;
                    end
                end
                HALF: begin
                    if (acc && dq) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (dq) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (dq) begin
                        state_d        = HALF;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // Buffer FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    ex_mem_buffer_reg #(
        .WIDTH (PAYLOAD_W)
    ) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .in    (main_in),
        .out   (main_q)
    );

    ex_mem_buffer_reg #(
        .WIDTH (PAYLOAD_W)
    ) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .in    (in_payload),
        .out   (skid_q)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign {out_pc, out_alu, out_br_addr, out_store_data, out_dest, out_ctrl} = main_q;

`ifdef EX_MEM_FWD_TAP_EN
    logic [PAYLOAD_W-1:0]   young;
    lc3b_control_word       young_ctrl;

    // Youngest held entry for forwarding: skid when FULL, main otherwise.
    always_comb begin
        young      = (state_q == FULL) ? skid_q : main_q;
        young_ctrl = lc3b_control_word'(young[CTRL_W-1:0]);
        fwd_valid  = (state_q != EMPTY) && !flush && young_ctrl.load_regfile;
        fwd_dest   = young[CTRL_W +: REG_W];
        fwd_data   = young[CTRL_W + REG_W + 2 * DATA_W +: DATA_W];
    end
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed scenarios followed by
// randomized traffic, checked against a queue model of a two-deep FIFO.
module tb_ex_mem_buffer;
    import ex_mem_buffer_pkg::*;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_pc;
    logic [DATA_W-1:0]   in_alu;
    logic [DATA_W-1:0]   in_br_addr;
    logic [DATA_W-1:0]   in_store_data;
    logic [REG_W-1:0]    in_dest;
    lc3b_control_word    in_ctrl;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_pc;
    logic [DATA_W-1:0]   out_alu;
    logic [DATA_W-1:0]   out_br_addr;
    logic [DATA_W-1:0]   out_store_data;
    logic [REG_W-1:0]    out_dest;
    lc3b_control_word    out_ctrl;
`ifdef EX_MEM_FWD_TAP_EN
    logic                fwd_valid;
    logic [REG_W-1:0]    fwd_dest;
    logic [DATA_W-1:0]   fwd_data;
`endif

    ex_mem_buffer #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_alu         (in_alu),
        .in_br_addr     (in_br_addr),
        .in_store_data  (in_store_data),
        .in_dest        (in_dest),
        .in_ctrl        (in_ctrl),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_alu        (out_alu),
        .out_br_addr    (out_br_addr),
        .out_store_data (out_store_data),
        .out_dest       (out_dest),
        .out_ctrl       (out_ctrl)
`ifdef EX_MEM_FWD_TAP_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] br;
        logic [DATA_W-1:0] sd;
        logic [REG_W-1:0]  dest;
        lc3b_control_word  ctrl;
    } item_t;

    item_t exp_q[$];
    item_t mon_it;
    int    n_pass   = 0;
    int    n_total  = 0;
    int    consumed = 0;
    bit    mon_en   = 0;
    bit    saw_cccc = 0;
    bit    force_lr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs just after an edge, then let the model
    // take the accepted entry (or the flush) on the next edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] alu,
                        input logic [REG_W-1:0] dest, input logic rdy, input logic fl);
        logic [7:0] c;
        bit         take;
        item_t      it;
        c             = 8'($urandom);
        if (force_lr) c[3] = 1'b1;
        in_valid      = v;
        in_alu        = alu;
        in_dest       = dest;
        in_pc         = 16'($urandom);
        in_br_addr    = 16'($urandom);
        in_store_data = 16'($urandom);
        in_ctrl       = c;
        out_ready     = rdy;
        flush         = fl;
        take          = v && (exp_q.size() < 2);
        it.pc   = in_pc;
        it.alu  = in_alu;
        it.br   = in_br_addr;
        it.sd   = in_store_data;
        it.dest = in_dest;
        it.ctrl = in_ctrl;
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (take) exp_q.push_back(it);
        #1;
    endtask

    // Monitor: mid-cycle, compare handshake flags and the head entry with
    // the model; an entry leaves the model when MEM takes it.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            if (out_valid && out_alu == 16'hCCCC) saw_cccc = 1;
`ifdef EX_MEM_FWD_TAP_EN
            if (exp_q.size() > 0 && !flush) begin
                chk("fwd_valid", 32'(fwd_valid), 32'(exp_q[$].ctrl.load_regfile));
                if (exp_q[$].ctrl.load_regfile) begin
                    chk("fwd_dest", 32'(fwd_dest), 32'(exp_q[$].dest));
                    chk("fwd_data", 32'(fwd_data), 32'(exp_q[$].alu));
                end
            end else begin
                chk("fwd_valid_idle", 32'(fwd_valid), 32'(0));
            end
`endif
            if (exp_q.size() > 0) begin
                mon_it = exp_q[0];
                chk("out_pc", 32'(out_pc), 32'(mon_it.pc));
                chk("out_alu", 32'(out_alu), 32'(mon_it.alu));
                chk("out_br_addr", 32'(out_br_addr), 32'(mon_it.br));
                chk("out_store_data", 32'(out_store_data), 32'(mon_it.sd));
                chk("out_dest", 32'(out_dest), 32'(mon_it.dest));
                chk("out_ctrl", 32'(out_ctrl), 32'(mon_it.ctrl));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_alu = '0; in_br_addr = '0; in_store_data = '0;
        in_dest = '0; in_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_out_alu", 32'(out_alu), 32'(0));
        chk("reset_out_ctrl", 32'(out_ctrl), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // Streaming at one per cycle.
        for (int k = 1; k <= 5; k++) step(1'b1, 16'(k), 3'(k), 1'b1, 1'b0);
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

        // Stall into FULL, then drain in order.
        step(1'b1, 16'h1111, 3'd1, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 3'd2, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 3'd3, 1'b0, 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'(0));
        chk("stall_out_alu", 32'(out_alu), 32'(16'h1111));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        chk("after_dq_in_ready", 32'(in_ready), 32'(1));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

        // Flush while FULL with EX offering an entry.
        saw_cccc = 0;
        step(1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 3'd2, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 3'd3, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        // Flush while HALF discards a simultaneous accept.
        step(1'b1, 16'h1234, 3'd4, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 3'd5, 1'b0, 1'b1);
        chk("flush_half_out_valid", 32'(out_valid), 32'(0));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        chk("flush_no_cccc", 32'(saw_cccc), 32'(0));

        // Flush coinciding with a dequeue: consumed exactly once.
        step(1'b1, 16'h5555, 3'd6, 1'b0, 1'b0);
        c0 = consumed;
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b1);
        chk("flush_dq_consumed", 32'(consumed - c0), 32'(1));
        chk("flush_dq_out_valid", 32'(out_valid), 32'(0));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        chk("flush_dq_no_dup", 32'(consumed - c0), 32'(1));

`ifdef EX_MEM_FWD_TAP_EN
        force_lr = 1;
        step(1'b1, 16'h0010, 3'd1, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 3'd2, 1'b0, 1'b0);
        chk("fwd_full_dest", 32'(fwd_dest), 32'(2));
        chk("fwd_full_data", 32'(fwd_data), 32'(16'h0020));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        chk("fwd_half_dest", 32'(fwd_dest), 32'(2));
        chk("fwd_half_data", 32'(fwd_data), 32'(16'h0020));
        step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
        force_lr = 0;
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 7), 16'($urandom), 3'($urandom),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset while FULL.
        step(1'b1, 16'h4444, 3'd1, 1'b0, 1'b0);
        step(1'b1, 16'h6666, 3'd2, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 3'd3, 1'b0, 1'b0);
        mon_en = 0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'(0));
        chk("async_rst_in_ready", 32'(in_ready), 32'(1));
        chk("async_rst_out_alu", 32'(out_alu), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;
        for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0100 + k), 3'(k), 1'b1, 1'b0);
        repeat (3) step(1'b0, 16'h0, 3'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
